// File: rtl/dither_gen_lfsr.sv
// Dual Galois-LFSR dither source: binary +/-1, RPDF, TPDF or off, with attenuation.
// Define DITHER_HPF_EN for first-order high-passed RPDF/TPDF output.
module dither_gen_lfsr #(
   parameter int                LFSR_W = 18,
   parameter logic [LFSR_W-1:0] TAPS   = 18'h20400,
   parameter logic [LFSR_W-1:0] SEED_A = LFSR_W'(1),
   parameter logic [LFSR_W-1:0] SEED_B = 18'h2AAAA,
   parameter int                OUT_W  = 4
) (
   input  logic                       clk,
   input  logic                       rstn,
   input  logic                       clk_en,
   input  logic [1:0]                 mode,
   input  logic [$clog2(OUT_W)-1:0]   att,
   input  logic                       seed_wr,
   input  logic [LFSR_W-1:0]          seed,
   output logic signed [OUT_W-1:0]    dither,
   output logic                       dither_vld
);

   logic [LFSR_W-1:0]       lfsr_a_q, lfsr_a_d;
   logic [LFSR_W-1:0]       lfsr_b_q, lfsr_b_d;
   logic signed [OUT_W-1:0] dither_q, dither_d;
   logic                    dither_vld_q, dither_vld_d;

   logic signed [OUT_W-1:0] r_a, r_b, bin_s, tpdf_s, pre_s, shf_s, out_s;
   logic signed [OUT_W:0]   sum_s;

`ifdef DITHER_HPF_EN
   logic signed [OUT_W-1:0] p_q, p_d, p_nxt, hpf_s;
   logic signed [OUT_W:0]   diff_s;
`endif

   // An all-zero register reloads its default seed instead of stepping.
   function automatic logic [LFSR_W-1:0] lfsr_step(
      input logic [LFSR_W-1:0] s,
      input logic [LFSR_W-1:0] dflt
   );
      if (s == '0)
         return dflt;
      return {1'b0, s[LFSR_W-1:1]} ^ (s[0] ? TAPS : '0);
   endfunction

   always_comb begin
      r_a    = $signed(lfsr_a_q[OUT_W-1:0]);
      r_b    = $signed(lfsr_b_q[OUT_W-1:0]);
      sum_s  = {r_a[OUT_W-1], r_a} + {r_b[OUT_W-1], r_b};
      tpdf_s = sum_s[OUT_W:1];
      bin_s  = lfsr_a_q[0] ? '1 : OUT_W'(1);
      pre_s  = (mode == 2'b01) ? r_a : tpdf_s;
`ifdef DITHER_HPF_EN
      diff_s = {pre_s[OUT_W-1], pre_s} - {p_q[OUT_W-1], p_q};
      if (diff_s[OUT_W] != diff_s[OUT_W-1])
         hpf_s = {diff_s[OUT_W], {(OUT_W-1){~diff_s[OUT_W]}}};
      else
         hpf_s = diff_s[OUT_W-1:0];
      shf_s  = hpf_s;
      p_nxt  = (mode[0] ^ mode[1]) ? pre_s : '0;
`else
      shf_s  = pre_s;
`endif
      unique case (mode)
         2'b00:   out_s = bin_s;
         2'b01:   out_s = shf_s >>> att;
         2'b10:   out_s = shf_s >>> att;
         default: out_s = '0;
      endcase
   end

   always_comb begin
      lfsr_a_d     = lfsr_a_q;
      lfsr_b_d     = lfsr_b_q;
      dither_d     = dither_q;
      dither_vld_d = 1'b0;
`ifdef DITHER_HPF_EN
      p_d          = p_q;
`endif
      if (seed_wr) begin
         lfsr_a_d = (seed == '0) ? SEED_A : seed;
         lfsr_b_d = (&seed) ? SEED_B : ~seed;
      end else if (clk_en) begin
         lfsr_a_d     = lfsr_step(lfsr_a_q, SEED_A);
         lfsr_b_d     = lfsr_step(lfsr_b_q, SEED_B);
         dither_d     = out_s;
         dither_vld_d = 1'b1;
`ifdef DITHER_HPF_EN
         p_d          = p_nxt;
`endif
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         lfsr_a_q     <= SEED_A;
         lfsr_b_q     <= SEED_B;
         dither_q     <= '0;
         dither_vld_q <= 1'b0;
      end else begin
         lfsr_a_q     <= lfsr_a_d;
         lfsr_b_q     <= lfsr_b_d;
         dither_q     <= dither_d;
         dither_vld_q <= dither_vld_d;
      end
   end

`ifdef DITHER_HPF_EN
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)
         p_q <= '0;
      else
         p_q <= p_d;
   end
`endif

   assign dither     = dither_q;
   assign dither_vld = dither_vld_q;

endmodule

// File: tb/tb_dither_gen_lfsr.sv
// Self-checking bench for dither_gen_lfsr (default parameters).
// Vector table, hand sequences, and a queue scoreboard against a behavioural model.
module tb_dither_gen_lfsr;

   localparam logic [17:0] TP = 18'h20400;
   localparam logic [17:0] SA = 18'd1;
   localparam logic [17:0] SB = 18'h2AAAA;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic        clk_en = 1'b0;
   logic [1:0]  mode = 2'b00;
   logic [1:0]  att = 2'b00;
   logic        seed_wr = 1'b0;
   logic [17:0] seed = 18'd0;
   logic [3:0]  dither;
   logic        dither_vld;

   always #5 clk = ~clk;

   dither_gen_lfsr dut (
      .clk        (clk),
      .rstn       (rstn),
      .clk_en     (clk_en),
      .mode       (mode),
      .att        (att),
      .seed_wr    (seed_wr),
      .seed       (seed),
      .dither     (dither),
      .dither_vld (dither_vld)
   );

   int          n_chk = 0;
   int          n_fail = 0;
   logic [3:0]  sb_q[$];
   logic [17:0] ma, mb;
   logic [3:0]  m_dith;
   int          m_p;

   typedef struct {
      logic [17:0] sd;
      logic [1:0]  md;
      logic [1:0]  at;
      logic [3:0]  exp;
   } vec_t;
   vec_t tbl[12];

   function automatic logic [17:0] m_step(input logic [17:0] s,
                                          input logic [17:0] d);
      if (s == 18'd0)
         return d;
      return (s >> 1) ^ (s[0] ? TP : 18'd0);
   endfunction

   function automatic int sx4(input logic [3:0] v);
      return v[3] ? int'(v) - 16 : int'(v);
   endfunction

   function automatic int m_pre(input logic [1:0] md);
      if (md == 2'b01)
         return sx4(ma[3:0]);
      return (sx4(ma[3:0]) + sx4(mb[3:0])) >>> 1;
   endfunction

   function automatic logic [3:0] m_out(input logic [1:0] md,
                                        input logic [1:0] at);
      int v;
      logic [31:0] r;
      if (md == 2'b00)
         return ma[0] ? 4'hF : 4'h1;
      if (md == 2'b11)
         return 4'h0;
      v = m_pre(md);
`ifdef DITHER_HPF_EN
      v = v - m_p;
      if (v > 7) v = 7;
      if (v < -8) v = -8;
`endif
      v = v >>> at;
      r = v;
      return r[3:0];
   endfunction

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic cyc(input logic en, input logic wr, input logic [17:0] sd,
                      input logic [1:0] md, input logic [1:0] at);
      logic       ev;
      logic [3:0] e;
      clk_en  = en;
      seed_wr = wr;
      seed    = sd;
      mode    = md;
      att     = at;
      ev      = 1'b0;
      if (wr) begin
         ma = (sd == 18'd0) ? SA : sd;
         mb = (&sd) ? SB : ~sd;
      end else if (en) begin
         e = m_out(md, at);
         m_p = (md == 2'b01 || md == 2'b10) ? m_pre(md) : 0;
         ma = m_step(ma, SA);
         mb = m_step(mb, SB);
         sb_q.push_back(e);
         m_dith = e;
         ev = 1'b1;
      end
      @(posedge clk);
      #1;
      chk("vld", dither_vld, ev);
      if (ev) begin
         e = sb_q.pop_front();
         chk("dither", dither, e);
      end else begin
         chk("hold", dither, m_dith);
      end
      clk_en  = 1'b0;
      seed_wr = 1'b0;
   endtask

   task automatic do_reset();
      rstn = 1'b0;
      #1;
      chk("rst_dither", dither, 4'h0);
      chk("rst_vld", dither_vld, 1'b0);
      ma = SA;
      mb = SB;
      m_dith = 4'h0;
      m_p = 0;
      sb_q.delete();
      @(posedge clk);
      #1;
      rstn = 1'b1;
   endtask

   // Finds a seed and step count k where A's low nibble is ta (and B's is tb,
   // or A's next nibble is tn, when those are non-negative).
   task automatic find(input int ta, input int tb, input int tn,
                       output logic [17:0] s, output int k, output bit ok);
      logic [17:0] a, b, c;
      ok = 1'b0;
      s = 18'd0;
      k = 0;
      for (int t = 0; t < 2000 && !ok; t++) begin
         c = 18'($urandom_range(1, 18'h3FFFE));
         a = c;
         b = ~c;
         for (int j = 0; j < 40 && !ok; j++) begin
            if (int'(a[3:0]) == ta &&
                (tb < 0 || int'(b[3:0]) == tb) &&
                (tn < 0 || int'(m_step(a, SA) & 18'hF) == tn)) begin
               ok = 1'b1;
               s = c;
               k = j;
            end
            a = m_step(a, SA);
            b = m_step(b, SB);
         end
      end
   endtask

   initial begin
      logic [17:0] fs;
      int          fk;
      bit          fok;

      tbl[0]  = '{18'h0000A, 2'b01, 2'd2, 4'hE};
      tbl[1]  = '{18'h0000A, 2'b01, 2'd0, 4'hA};
      tbl[2]  = '{18'h0000A, 2'b10, 2'd0, 4'hF};
      tbl[3]  = '{18'h0000A, 2'b00, 2'd3, 4'h1};
      tbl[4]  = '{18'h0000A, 2'b11, 2'd0, 4'h0};
      tbl[5]  = '{18'h3FFFF, 2'b10, 2'd0, 4'hC};
      tbl[6]  = '{18'h00000, 2'b10, 2'd0, 4'h0};
      tbl[7]  = '{18'h00000, 2'b00, 2'd0, 4'hF};
      tbl[8]  = '{18'h00007, 2'b01, 2'd3, 4'h0};
      tbl[9]  = '{18'h00008, 2'b01, 2'd3, 4'hF};
      tbl[10] = '{18'h00007, 2'b10, 2'd1, 4'hF};
      tbl[11] = '{18'h00006, 2'b01, 2'd1, 4'h3};

      do_reset();

      cyc(1, 0, 0, 2'b00, 2'd0);
      chk("first_m1", dither, 4'hF);
      cyc(1, 0, 0, 2'b00, 2'd0);
      chk("second_p1", dither, 4'h1);
      cyc(1, 0, 0, 2'b00, 2'd0);

      // Seed load in the same cycle as a strobe: load wins, output holds.
      cyc(1, 1, 18'd0, 2'b10, 2'd0);
      cyc(1, 0, 0, 2'b10, 2'd0);
      chk("zero_seed_tpdf", dither, 4'h0);
      cyc(1, 1, 18'd0, 2'b00, 2'd0);
      cyc(1, 0, 0, 2'b00, 2'd0);
      chk("zero_seed_bin", dither, 4'hF);

      for (int i = 0; i < 10; i++)
         cyc(0, 0, 0, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));

`ifndef DITHER_HPF_EN
      for (int i = 0; i < 12; i++) begin
         cyc(0, 1, tbl[i].sd, tbl[i].md, tbl[i].at);
         cyc(1, 0, 0, tbl[i].md, tbl[i].at);
         chk($sformatf("tbl%0d", i), dither, tbl[i].exp);
      end

      find(7, 7, -1, fs, fk, fok);
      chk("find77", fok, 1'b1);
      if (fok) begin
         cyc(0, 1, fs, 2'b10, 2'd0);
         for (int j = 0; j < fk; j++)
            cyc(1, 0, 0, 2'b10, 2'd0);
         cyc(1, 0, 0, 2'b10, 2'd0);
         chk("tpdf_max", dither, 4'h7);
      end
      find(8, 8, -1, fs, fk, fok);
      chk("find88", fok, 1'b1);
      if (fok) begin
         cyc(0, 1, fs, 2'b10, 2'd0);
         for (int j = 0; j < fk; j++)
            cyc(1, 0, 0, 2'b10, 2'd0);
         cyc(1, 0, 0, 2'b10, 2'd0);
         chk("tpdf_min", dither, 4'h8);
      end
`else
      do_reset();
      find(7, -1, 8, fs, fk, fok);
      chk("find78", fok, 1'b1);
      if (fok) begin
         cyc(0, 1, fs, 2'b11, 2'd0);
         for (int j = 0; j < fk; j++)
            cyc(1, 0, 0, 2'b11, 2'd0);
         cyc(1, 0, 0, 2'b01, 2'd0);
         chk("hpf_first", dither, 4'h7);
         cyc(1, 0, 0, 2'b01, 2'd0);
         chk("hpf_sat", dither, 4'h8);
      end
`endif

      for (int i = 0; i < 300; i++)
         cyc(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 15) == 0),
             18'($urandom), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));

      // Mid-stream reset must restart the post-reset sequence.
      for (int i = 0; i < 5; i++)
         cyc(1, 0, 0, 2'b01, 2'd0);
      do_reset();
      cyc(1, 0, 0, 2'b00, 2'd0);
      chk("rerun_first", dither, 4'hF);
      cyc(1, 0, 0, 2'b00, 2'd0);
      chk("rerun_second", dither, 4'h1);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/dither_gen_lfsr.md
Name: dither_gen_lfsr

Overview:
Parametrised pseudo-random dither source for the DAC digital path, succeeding the fixed 18-stage ±1 generator. Two independent Galois LFSRs of configurable length feed a selectable-PDF output stage: binary ±1, rectangular multi-bit, triangular multi-bit, or off. The output has programmable attenuation, a runtime seed-load port, and lock-up protection. Sits beside the noise shaper/modulator; advances only on the shared clk_en sample strobe.

Parameters:
LFSR_W, 18, LFSR length in bits (8..32)
TAPS, 18'h20400, Galois feedback mask (default x^18+x^11+1, maximal length)
SEED_A, 1, reset/default seed of LFSR A (must be nonzero)
SEED_B, 18'h2AAAA, reset/default seed of LFSR B (must be nonzero)
OUT_W, 4, signed output width (2..LFSR_W)

Ports:
clk  in  1  system clock
rstn  in  1  asynchronous active-low reset
clk_en  in  1  sample strobe; LFSRs and output advance only when high
mode  in  2  00 binary ±1, 01 RPDF, 10 TPDF, 11 off (zero)
att  in  $clog2(OUT_W)  arithmetic right-shift applied to multi-bit output
seed_wr  in  1  single-cycle seed load request
seed  in  LFSR_W  seed value for LFSR A; LFSR B gets ~seed
dither  out  OUT_W  signed dither sample, registered
dither_vld  out  1  one-cycle pulse when dither updates

Behaviour:
- Reset (async, rstn=0): lfsr_a=SEED_A, lfsr_b=SEED_B, dither=0, dither_vld=0.
- LFSR step (per LFSR, on clk_en): next = {1'b0, s[LFSR_W-1:1]} ^ (s[0] ? TAPS : 0).
- Output computed from the pre-step state at an edge with clk_en=1; registered at that edge. Latency: dither reflects the state held before the edge; dither_vld=1 for the following cycle only.
- mode 00: dither = lfsr_a[0] ? -1 : +1, sign-extended to OUT_W. att ignored.
- mode 01: r_a = lfsr_a[OUT_W-1:0] as signed; dither = r_a >>> att.
- mode 10: sum = r_a + r_b at OUT_W+1 bits (r_b = lfsr_b[OUT_W-1:0] signed); t = sum >>> 1 (always fits OUT_W); dither = t >>> att.
- mode 11: dither = 0, dither_vld still pulses, LFSRs still advance.
- mode/att sampled only at clk_en edges; changes between strobes have no effect on dither.
- clk_en=0: all state and dither hold; dither_vld=0.
- seed_wr=1: at that edge lfsr_a=seed, lfsr_b=~seed. Priority over clk_en: no advance, dither holds, dither_vld=0.
- Zero protection: seed==0 loads SEED_A into A. ~seed==0 (all-ones seed) loads SEED_B into B.
- Lock-up guard: if either LFSR holds all-zero at a clk_en edge, that LFSR reloads its default seed instead of stepping. Output is still computed from the zero state.
- Period of each LFSR with a primitive TAPS: 2^LFSR_W-1 clk_en strobes.
- Reset asserted mid-stream: immediate return to reset values; first strobe after release reproduces the post-reset sequence exactly.

Optional Feature:
DITHER_HPF_EN
- Defined: first-order high-passed dither for modes 01/10.
  - Register p holds the previous pre-attenuation sample; reset p=0.
  - d = cur - p at OUT_W+1 bits, saturated to OUT_W range, then >>> att.
  - p updates on each clk_en output edge.
  - Mode 00 and 11 unaffected, and p is cleared while in those modes.
- Undefined: no p register; output exactly as in Behaviour.

Test Plan:
- Reset, mode=00, clk_en every cycle -> first dither=-1 (4'hF, lfsr_a=1); second +1 (lfsr_a=18'h20400); dither_vld high each cycle after first strobe.
- mode=00, count strobes until lfsr_a returns to 1 -> exactly 262143 strobes; never all-zero.
- seed_wr=1 with seed=0 and clk_en=1 same cycle -> lfsr_a=1, lfsr_b=18'h3FFFF, dither unchanged, dither_vld=0.
- mode=01, att=2, lfsr_a[3:0]=4'b1010 -> dither=4'b1110 (-2).
- mode=10, r_a=7, r_b=7 -> dither=7; r_a=-8, r_b=-8 -> dither=-8; clk_en=0 for 10 cycles -> dither holds, dither_vld=0.
- DITHER_HPF_EN, mode=01, att=0, samples 7 then -8 -> second output saturates to -8.
